// File: rtl/window_gen3x3_if.sv
// Pixel-in / window-out handshake bundle for window_gen3x3.
// master: pixel source plus window consumer side. slave: the window generator.
interface window_gen3x3_if #(
    parameter int input_width = 8
);
    logic [input_width-1:0]   pix_data;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [9*input_width-1:0] win_data;
    logic                     win_valid;
    logic                     win_ready;
    logic                     win_last;
    logic [15:0]              frame_cnt;

    modport master (
        output pix_data, pix_valid, win_ready,
        input  pix_ready, win_data, win_valid, win_last, frame_cnt
    );

    modport slave (
        input  pix_data, pix_valid, win_ready,
        output pix_ready, win_data, win_valid, win_last, frame_cnt
    );
endinterface

// File: rtl/window_gen3x3.sv
// Streaming 3x3 sliding-window generator ("valid" windows, no padding).
// Raster pixels go into three rotating row memories; each accepted pixel
// shifts a new column {row r-2, row r-1, incoming pixel} into a 3x3 window.
// Windows ending at (r>=2, c>=2) are presented through one output register.
// Optional feature macro: WINDOW_GEN_FRAME_CNT_EN enables the 16-bit
// completed-frame counter; without it frame_cnt is tied to zero.
module window_gen3x3 #(
    parameter int input_width = 8,
    parameter int im_dim      = 28
) (
    input  logic            clk_i,
    input  logic            rst_i,
    window_gen3x3_if.slave  bus
);
    localparam int W  = input_width;
    localparam int CW = (im_dim > 1) ? $clog2(im_dim) : 1;
    localparam logic [CW-1:0] LAST = CW'(im_dim - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t              state;
    logic [CW-1:0]       c;
    logic [CW-1:0]       r;
    logic [2:0]          sel;      // one-hot: memory that receives row r
    logic [2:0]          sel_m1;   // memory holding row r-1
    logic [2:0]          sel_m2;   // memory holding row r-2

    logic [W-1:0]        mem0 [im_dim];
    logic [W-1:0]        mem1 [im_dim];
    logic [W-1:0]        mem2 [im_dim];

    logic [9*W-1:0]      sh;       // working window, slice 3*i+j = row i, col j
    logic [9*W-1:0]      win_next;
    logic [W-1:0]        top;
    logic [W-1:0]        mid;

    logic                accept;
    logic                emit;
    logic                row_end;
    logic                frame_end;

    logic                win_vld_p0;
    logic                win_last_p0;
    logic [9*W-1:0]      win_data_p0;

    assign bus.pix_ready = !win_vld_p0 || bus.win_ready;
    assign bus.win_valid = win_vld_p0;
    assign bus.win_last  = win_last_p0;
    assign bus.win_data  = win_data_p0;

    assign accept    = bus.pix_valid && bus.pix_ready;
    assign row_end   = (c == LAST);
    assign frame_end = row_end && (r == LAST);
    assign emit      = accept && (state == STREAM) && (c >= CW'(2));

    // Older rows are found by rotating the write pointer; read in the accept cycle
    always_comb begin
        sel_m1 = {sel[0], sel[2:1]};
        sel_m2 = {sel[1:0], sel[2]};
        top = ({W{sel_m2[0]}} & mem0[c]) | ({W{sel_m2[1]}} & mem1[c]) |
              ({W{sel_m2[2]}} & mem2[c]);
        mid = ({W{sel_m1[0]}} & mem0[c]) | ({W{sel_m1[1]}} & mem1[c]) |
              ({W{sel_m1[2]}} & mem2[c]);
        win_next = '0;
        for (int i = 0; i < 3; i++) begin
            win_next[(3*i)*W   +: W] = sh[(3*i+1)*W +: W];
            win_next[(3*i+1)*W +: W] = sh[(3*i+2)*W +: W];
        end
        win_next[2*W +: W] = top;
        win_next[5*W +: W] = mid;
        win_next[8*W +: W] = bus.pix_data;
    end

    // Row memories: store the incoming pixel at its column in row r's memory
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (sel[0]) mem0[c] <= bus.pix_data;
            if (sel[1]) mem1[c] <= bus.pix_data;
            if (sel[2]) mem2[c] <= bus.pix_data;
        end
    end

    // Working window shifts left on every accepted pixel; columns 0,1 refill it
    always_ff @(posedge clk_i) begin
        if (accept) begin
            sh <= win_next;
        end
    end

    // Row/column bookkeeping, FILL/STREAM state and the output register (p0)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= FILL;
            c           <= '0;
            r           <= '0;
            sel         <= 3'b001;
            win_vld_p0  <= 1'b0;
            win_last_p0 <= 1'b0;
            win_data_p0 <= '0;
        end else begin
            if (accept) begin
                if (row_end) begin
                    c <= '0;
                    if (frame_end) begin
                        r   <= '0;
                        sel <= 3'b001;
                    end else begin
                        r   <= r + 1'b1;
                        sel <= {sel[1:0], sel[2]};
                    end
                end else begin
                    c <= c + 1'b1;
                end
                case (state)
                    FILL:    if (row_end && (r == CW'(1))) state <= STREAM;
                    STREAM:  if (frame_end) state <= FILL;
                    default: state <= FILL;
                endcase
                win_vld_p0  <= emit;
                win_last_p0 <= emit && frame_end;
                if (emit) begin
                    win_data_p0 <= win_next;
                end
            end else if (bus.win_ready) begin
                win_vld_p0  <= 1'b0;
                win_last_p0 <= 1'b0;
            end
        end
    end

`ifdef WINDOW_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // A frame counts as complete when its final window is taken downstream
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else if (win_vld_p0 && bus.win_ready && win_last_p0) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif
endmodule

// File: doc/window_gen3x3.md
# window_gen3x3

Streaming 3×3 sliding-window generator for the CNN front end. It accepts a raster-order pixel stream (one pixel per handshake) and writes it into three rotating row memories. It emits every fully-populated 3×3 neighbourhood ("valid" convolution, no padding) as one flat 9-pixel word to the downstream convolution datapath. It sits between the pixel source and the MAC array, and owns the row/column bookkeeping and read addressing that the line buffers need.

## Interface
- `input_width`, 8, bits per pixel
- `im_dim`, 28, image width and height in pixels (square frame, ≥ 3)
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `pix_data`  in  input_width  pixel value
- `pix_valid`  in  1  pixel offered
- `pix_ready`  out  1  block can accept a pixel this cycle
- `win_data`  out  9*input_width  window; slice `[(3*i+j)*input_width +: input_width]` = pixel at (row r-2+i, col c-2+j)
- `win_valid`  out  1  window present on `win_data`
- `win_ready`  in  1  downstream accepts window
- `win_last`  out  1  qualifies the final window of a frame
- `frame_cnt`  out  16  completed frames (see Configuration)

## Operation
- Pixel accepted when `pix_valid && pix_ready`; every accepted pixel advances column counter `c` (0..im_dim-1, wraps to 0 and increments row `r`); `r` wraps im_dim-1 → 0 at end of frame.
- Three row memories of im_dim entries each; pixel (r,c) written to memory `r mod 3`, address `c`. Row-select pointer rotates at each row wrap, no modulo arithmetic.
- 3×3 window register: on each accepted pixel, columns shift left by one; new right column = {mem[(r-2) mod 3][c], mem[(r-1) mod 3][c], pix_data}, read combinationally in the same cycle.
- Window emitted for accepted pixel (r,c) iff r ≥ 2 and c ≥ 2; yields (im_dim-2)² windows/frame (676 at default).
- States: FILL (r < 2, no output), STREAM (r ≥ 2). STREAM → FILL on acceptance of pixel (im_dim-1, im_dim-1). Window shift register is not cleared at row start; columns 0,1 refill it before emission.
- `win_last` = 1 with the window from pixel (im_dim-1, im_dim-1); 0 otherwise.
- Single output register: `pix_ready = !win_valid || win_ready`. Window held stable while `win_valid && !win_ready`.
- Row-memory contents are not reset; they are never observed before being rewritten.

## Timing
- Reset values: `win_valid`=0, `win_last`=0, `win_data`=0, `frame_cnt`=0, `r`=`c`=0, state FILL; `pix_ready`=1 the first cycle after reset.
- Latency: window appears at `win_valid` one cycle after the edge that accepts its bottom-right pixel.
- Throughput: one pixel and one window per cycle with `win_ready` held high; no bubbles at row or frame boundaries.
- Simultaneous `win_valid && win_ready` and new pixel accepted: register reloads same edge, `win_valid` stays 1.
- Accepted pixel with no window (c < 2 or r < 2) while current window is consumed: `win_valid` falls to 0.
- Reset mid-frame: counters, state and outputs return to reset values at the next edge; the next accepted pixel is (0,0) of a new frame; any pending window is discarded.

## Configuration
- `WINDOW_GEN_FRAME_CNT_EN`: when defined, `frame_cnt` increments (wrapping at 16 bits) on the edge where the `win_last` window is consumed (`win_valid && win_ready && win_last`). When undefined, `frame_cnt` is tied to 0 and the counter is not synthesised. All other behaviour is identical.

## Test plan
- Ramp frame p(r,c) = (r*28+c) & 0xFF, `win_ready`=1 → first window one cycle after pixel 58: rows {0,1,2},{28,29,30},{56,57,58}; exactly 676 windows; `win_last` on window ending at 783&0xFF = 15 (rows {213,214,215},{241,242,243},{13,14,15}).
- Same frame, `win_ready` toggling 1-0-0 repeatedly → identical 676-window sequence, no drops or duplicates, `pix_ready` low exactly while a window is stalled.
- Two back-to-back frames, second = first + 1 per pixel → second frame's first window = first frame's + 1 per element; no window spans the frame boundary; `frame_cnt` = 2 with macro, 0 without.
- `rst_i` pulsed after 400 pixels → `win_valid` = 0 next cycle; fresh ramp frame yields the exact result of scenario 1.
- `im_dim`=3, pixels 1..9 → exactly one window {1..9} with `win_last`=1, one cycle after pixel 9 accepted.
- `pix_valid` gaps of random length inside rows → window content unchanged versus gap-free run.
